mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width; only 32 or 64 are legal.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, destination register index width.
REQ-003 SHALL have parameter CNT_W, default 32, retire counter width.
REQ-004 SHALL use the derived constant OFF_W = log2(WORD_SIZE/8), the byte-offset width: 2 for WORD_SIZE=32, 3 for WORD_SIZE=64.
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports in_valid in 1 and in_ready out 1, the MEM-side handshake.
REQ-008 SHALL have ports stall in 1 (hold the current entry) and flush in 1 (kill the stage).
REQ-009 SHALL have ports wbs in 3 (writeback select), reg_we_in in 1 (instruction writes rd) and rdn_in in REG_ADDR_W (rd index).
REQ-010 SHALL have ports addr_lo in OFF_W (load address low bits), alu_out in WORD_SIZE and mrd in WORD_SIZE (raw memory word).
REQ-011 SHALL have outputs wb_valid 1, wb_we 1, rdn REG_ADDR_W, rdd WORD_SIZE, misalign 1 and retire_cnt CNT_W.

Function
REQ-012 SHALL drive in_ready = !(wb_valid && stall), combinationally.
REQ-013 SHALL capture on a rising edge when in_valid && in_ready && !flush, giving outputs valid 1 cycle later.
REQ-014 SHALL set wb_valid to 0 on an edge with no capture and no hold; rdn, rdd, wb_we and misalign keep their values, but wb_we SHALL be qualified by wb_valid (wb_we=0 whenever wb_valid=0).
REQ-015 SHALL hold all outputs unchanged on an edge with wb_valid && stall && !flush.
REQ-016 SHALL, on an edge with flush=1, clear wb_valid, wb_we and misalign to 0 and hold rdn and rdd; flush overrides both capture and stall.
REQ-017 SHALL form the lane value L = mrd shifted right by 8*addr_lo bits, logically.
REQ-018 SHALL compute rdd for each wbs code:
- 0: alu_out
- 1: sign-extended L[7:0]
- 2: sign-extended L[15:0]
- 3: zero-extended L[7:0]
- 4: zero-extended L[15:0]
- 5: sign-extended L[31:0]
- 6: zero-extended L[31:0] if WORD_SIZE=64, else same as code 5
- 7: L if WORD_SIZE=64, else illegal
REQ-019 SHALL treat a capture as misaligned when:
- wbs in {2,4} and addr_lo[0]!=0;
- wbs in {5,6} and addr_lo[1:0]!=0;
- wbs=7 and addr_lo!=0.
wbs 0, 1 and 3 are never misaligned.
REQ-020 SHALL, for a misaligned capture, set misalign=1, rdd=0 and wb_we=0, with wb_valid=1.
REQ-021 SHALL, for an illegal capture (wbs=7 with WORD_SIZE=32), set rdd=0, wb_we=0, misalign=0 and wb_valid=1.
REQ-022 SHALL set wb_we = reg_we_in && (rdn_in!=0) && !misaligned && !illegal at capture; a write to x0 is never enabled.
REQ-023 SHALL set rdn = rdn_in on every capture, including misaligned, illegal and x0 cases.
REQ-024 SHALL increment retire_cnt by 1 on every edge where wb_valid=1 && stall=0, with or without flush; it wraps modulo 2^CNT_W.
REQ-025 SHALL, when stall=1, wb_valid=0 and in_valid=1, capture (in_ready=1); stall affects only a valid entry.

Reset
REQ-026 SHALL, while rstn=0, asynchronously force wb_valid=0, wb_we=0, rdn=0, rdd=0, misalign=0 and retire_cnt=0.
REQ-027 SHALL discard an in-flight entry when reset is asserted mid-operation, and capture nothing at the first edge after deassertion unless in_valid=1.

Verification
REQ-028 SHALL be covered: WORD_SIZE=32; wbs=1, addr_lo=2, mrd=0x1280_7F00, rdn_in=3, reg_we_in=1 -> next cycle rdd=0xFFFF_FF80, wb_we=1, rdn=3; same with wbs=3 -> rdd=0x0000_0080.
REQ-029 SHALL be covered: WORD_SIZE=32; wbs=2, addr_lo=1 -> misalign=1, wb_we=0, rdd=0, wb_valid=1; then wbs=4, addr_lo=2, mrd=0xBEEF_0000 -> rdd=0x0000_BEEF, misalign=0.
REQ-030 SHALL be covered: WORD_SIZE=64; wbs=5, addr_lo=4, mrd=0x8000_0001_0000_0000 -> rdd=0xFFFF_FFFF_8000_0001; wbs=6 -> 0x0000_0000_8000_0001; wbs=7, addr_lo=0 -> rdd=mrd.
REQ-031 SHALL be covered: entry valid, stall=1 for 3 cycles with in_valid=1 -> in_ready=0 and outputs and retire_cnt frozen; stall drops -> new entry captured, retire_cnt +1.
REQ-032 SHALL be covered: flush=1 together with in_valid=1 -> next cycle wb_valid=0, wb_we=0; rdn_in=0 with reg_we_in=1 -> wb_we=0.
REQ-033 SHALL be covered: 5 back-to-back captures, then rstn pulsed low mid-stream -> all outputs 0 immediately; retire_cnt before the reset equals the number of valid, unstalled cycles.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extends the load lane (or ALU result),
// flags misaligned/illegal loads, and counts retired instructions.
module mem_wb_stage #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    localparam int OFF_W     = $clog2(WORD_SIZE / 8)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [2:0]            wbs,
    input  logic                  reg_we_in,
    input  logic [REG_ADDR_W-1:0] rdn_in,
    input  logic [OFF_W-1:0]      addr_lo,
    input  logic [WORD_SIZE-1:0]  alu_out,
    input  logic [WORD_SIZE-1:0]  mrd,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] rdn,
    output logic [WORD_SIZE-1:0]  rdd,
    output logic                  misalign,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam bit C_WIDE = (WORD_SIZE == 64);

    function automatic logic [WORD_SIZE-1:0] f_ext8(input logic [7:0] b, input logic sgn);
        return {{(WORD_SIZE-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [WORD_SIZE-1:0] f_ext16(input logic [15:0] h, input logic sgn);
        return {{(WORD_SIZE-16){sgn & h[15]}}, h};
    endfunction

    function automatic logic f_misaligned(input logic [2:0] sel, input logic [OFF_W-1:0] lo);
        logic m;
        case (sel)
            3'd2, 3'd4: m = lo[0];
            3'd5, 3'd6: m = |lo[1:0];
            3'd7:       m = C_WIDE ? |lo : 1'b0;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    logic                  r_wb_valid;
    logic                  r_wb_we;
    logic [REG_ADDR_W-1:0] r_rdn;
    logic [WORD_SIZE-1:0]  r_rdd;
    logic                  r_misalign;
    logic [CNT_W-1:0]      r_retire_cnt;

    logic [WORD_SIZE-1:0]  w_lane;
    logic [WORD_SIZE-1:0]  w_word_s;
    logic [WORD_SIZE-1:0]  w_word_z;
    logic [WORD_SIZE-1:0]  w_sel;
    logic [WORD_SIZE-1:0]  w_rdd_next;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic                  w_we_next;
    logic                  w_capture;
    logic                  w_hold;

    assign w_lane = mrd >> {addr_lo, 3'b000};

    // 32-bit lane extension only differs between sign and zero on the wide datapath
    generate
        if (WORD_SIZE == 64) begin : g_wide
            assign w_word_s = {{(WORD_SIZE-32){w_lane[31]}}, w_lane[31:0]};
            assign w_word_z = {{(WORD_SIZE-32){1'b0}}, w_lane[31:0]};
        end else begin : g_narrow
            assign w_word_s = w_lane;
            assign w_word_z = w_lane;
        end
    endgenerate

    // writeback data select and capture qualification
    always_comb begin
        w_sel        = '0;
        w_misaligned = f_misaligned(wbs, addr_lo);
        w_illegal    = (wbs == 3'd7) && !C_WIDE;
        case (wbs)
            3'd0:    w_sel = alu_out;
            3'd1:    w_sel = f_ext8(w_lane[7:0], 1'b1);
            3'd2:    w_sel = f_ext16(w_lane[15:0], 1'b1);
            3'd3:    w_sel = f_ext8(w_lane[7:0], 1'b0);
            3'd4:    w_sel = f_ext16(w_lane[15:0], 1'b0);
            3'd5:    w_sel = w_word_s;
            3'd6:    w_sel = C_WIDE ? w_word_z : w_word_s;
            3'd7:    w_sel = w_lane;
            default: w_sel = '0;
        endcase
        if (w_misaligned || w_illegal) begin
            w_rdd_next = '0;
        end else begin
            w_rdd_next = w_sel;
        end
        w_we_next = reg_we_in && (rdn_in != '0) && !w_misaligned && !w_illegal;
    end

    assign in_ready  = !(r_wb_valid && stall);
    assign w_capture = in_valid && in_ready && !flush;
    assign w_hold    = r_wb_valid && stall;

    // pipeline entry: flush wins over capture, capture over hold; rdn/rdd persist
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_rdn      <= '0;
            r_rdd      <= '0;
            r_misalign <= 1'b0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_capture) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= w_we_next;
            r_rdn      <= rdn_in;
            r_rdd      <= w_rdd_next;
            r_misalign <= w_misaligned;
        end else if (!w_hold) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
        end
    end

    // an entry retires when it leaves the stage unstalled, flushed or not
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retire_cnt <= '0;
        end else if (r_wb_valid && !stall) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign rdn        = r_rdn;
    assign rdd        = r_rdd;
    assign misalign   = r_misalign;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a 32-bit (4-bit counter) and a 64-bit instance,
// table-driven captures plus stall/flush/reset sequences, scoreboard queues.
module tb_mem_wb_stage;

    typedef struct {
        logic        v;
        logic        we;
        logic        mis;
        logic [4:0]  rdn;
        logic [63:0] rdd;
    } st_t;

    typedef struct {
        bit          w64;
        logic [2:0]  wbs;
        logic [2:0]  alo;
        logic [63:0] mrd;
        logic [63:0] alu;
        logic [4:0]  rdn;
        logic        we_in;
        logic [63:0] exp_rdd;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    logic        clk, rstn, stall, flush, reg_we_in;
    logic [2:0]  wbs;
    logic [4:0]  rdn_in;
    logic        iv32, iv64;
    logic [1:0]  alo32;
    logic [2:0]  alo64;
    logic [31:0] mrd32, alu32;
    logic [63:0] mrd64, alu64;

    logic        rdy32, wv32, we32, mis32;
    logic [4:0]  rdn32;
    logic [31:0] rdd32;
    logic [3:0]  cnt32;
    logic        rdy64, wv64, we64, mis64;
    logic [4:0]  rdn64;
    logic [63:0] rdd64;
    logic [31:0] cnt64;

    int          n_vec  = 0;
    int          n_miss = 0;
    st_t         m32, m64, e32, e64;
    st_t         q32[$];
    st_t         q64[$];
    logic [3:0]  mc32;
    logic [31:0] mc64;
    vec_t        tbl[$];

    mem_wb_stage #(.WORD_SIZE(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(iv32), .in_ready(rdy32), .stall(stall), .flush(flush),
        .wbs(wbs), .reg_we_in(reg_we_in), .rdn_in(rdn_in), .addr_lo(alo32), .alu_out(alu32), .mrd(mrd32),
        .wb_valid(wv32), .wb_we(we32), .rdn(rdn32), .rdd(rdd32), .misalign(mis32), .retire_cnt(cnt32)
    );

    mem_wb_stage #(.WORD_SIZE(64), .REG_ADDR_W(5), .CNT_W(32)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(iv64), .in_ready(rdy64), .stall(stall), .flush(flush),
        .wbs(wbs), .reg_we_in(reg_we_in), .rdn_in(rdn_in), .addr_lo(alo64), .alu_out(alu64), .mrd(mrd64),
        .wb_valid(wv64), .wb_we(we64), .rdn(rdn64), .rdd(rdd64), .misalign(mis64), .retire_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t st_zero();
        st_t s;
        s.v = 1'b0; s.we = 1'b0; s.mis = 1'b0; s.rdn = 5'd0; s.rdd = 64'd0;
        return s;
    endfunction

    function automatic vec_t mkv(input bit w64, input logic [2:0] s, input logic [2:0] lo,
                                 input logic [63:0] m, input logic [63:0] a, input logic [4:0] rd,
                                 input logic wi, input logic [63:0] er, input logic ew, input logic em);
        vec_t v;
        v.w64 = w64; v.wbs = s; v.alo = lo; v.mrd = m; v.alu = a; v.rdn = rd;
        v.we_in = wi; v.exp_rdd = er; v.exp_we = ew; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("wb_valid32", 64'(wv32), 64'(m32.v));
        chk("wb_we32", 64'(we32), 64'(m32.we));
        chk("misalign32", 64'(mis32), 64'(m32.mis));
        chk("rdn32", 64'(rdn32), 64'(m32.rdn));
        chk("rdd32", 64'(rdd32), m32.rdd);
        chk("retire_cnt32", 64'(cnt32), 64'(mc32));
        chk("wb_valid64", 64'(wv64), 64'(m64.v));
        chk("wb_we64", 64'(we64), 64'(m64.we));
        chk("misalign64", 64'(mis64), 64'(m64.mis));
        chk("rdn64", 64'(rdn64), 64'(m64.rdn));
        chk("rdd64", rdd64, m64.rdd);
        chk("retire_cnt64", 64'(cnt64), 64'(mc64));
    endtask

    task automatic check_zero();
        chk("rst_wb_valid32", 64'(wv32), 64'd0);
        chk("rst_wb_we32", 64'(we32), 64'd0);
        chk("rst_rdn32", 64'(rdn32), 64'd0);
        chk("rst_rdd32", 64'(rdd32), 64'd0);
        chk("rst_misalign32", 64'(mis32), 64'd0);
        chk("rst_cnt32", 64'(cnt32), 64'd0);
        chk("rst_wb_valid64", 64'(wv64), 64'd0);
        chk("rst_rdd64", rdd64, 64'd0);
        chk("rst_rdn64", 64'(rdn64), 64'd0);
        chk("rst_cnt64", 64'(cnt64), 64'd0);
    endtask

    // One clock: predict ready/capture, push expectations, advance the model, compare.
    task automatic step();
        logic r32, r64, c32, c64;
        #1;
        r32 = !(m32.v && stall);
        r64 = !(m64.v && stall);
        chk("in_ready32", 64'(rdy32), 64'(r32));
        chk("in_ready64", 64'(rdy64), 64'(r64));
        c32 = iv32 && r32 && !flush;
        c64 = iv64 && r64 && !flush;
        if (c32) q32.push_back(e32);
        if (c64) q64.push_back(e64);
        @(posedge clk);
        #1;
        if (m32.v && !stall) mc32 = mc32 + 4'd1;
        if (m64.v && !stall) mc64 = mc64 + 32'd1;
        if (flush) begin
            m32.v = 1'b0; m32.we = 1'b0; m32.mis = 1'b0;
        end else if (c32) begin
            m32 = q32.pop_front();
        end else if (!(m32.v && stall)) begin
            m32.v = 1'b0; m32.we = 1'b0;
        end
        if (flush) begin
            m64.v = 1'b0; m64.we = 1'b0; m64.mis = 1'b0;
        end else if (c64) begin
            m64 = q64.pop_front();
        end else if (!(m64.v && stall)) begin
            m64.v = 1'b0; m64.we = 1'b0;
        end
        check_all();
    endtask

    task automatic apply(input vec_t v);
        st_t e;
        wbs = v.wbs; rdn_in = v.rdn; reg_we_in = v.we_in;
        e.v = 1'b1; e.we = v.exp_we; e.mis = v.exp_mis; e.rdn = v.rdn; e.rdd = v.exp_rdd;
        if (v.w64) begin
            iv64 = 1'b1; iv32 = 1'b0;
            alo64 = v.alo; mrd64 = v.mrd; alu64 = v.alu; e64 = e;
        end else begin
            iv32 = 1'b1; iv64 = 1'b0;
            alo32 = v.alo[1:0]; mrd32 = v.mrd[31:0]; alu32 = v.alu[31:0]; e32 = e;
        end
        step();
    endtask

    task automatic idle();
        iv32 = 1'b0; iv64 = 1'b0;
        step();
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0; reg_we_in = 1'b0; wbs = 3'd0; rdn_in = 5'd0;
        iv32 = 1'b0; iv64 = 1'b0; alo32 = 2'd0; alo64 = 3'd0;
        mrd32 = 32'd0; alu32 = 32'd0; mrd64 = 64'd0; alu64 = 64'd0;
        m32 = st_zero(); m64 = st_zero(); e32 = st_zero(); e64 = st_zero();
        mc32 = 4'd0; mc64 = 32'd0;

        // 32-bit datapath
        tbl.push_back(mkv(0, 3'd1, 3'd2, 64'h1280_7F00, 64'h0, 5'd3, 1'b1, 64'hFFFF_FF80, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd3, 3'd2, 64'h1280_7F00, 64'h0, 5'd3, 1'b1, 64'h0000_0080, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd2, 3'd1, 64'h1234_5678, 64'h0, 5'd4, 1'b1, 64'h0, 1'b0, 1'b1));
        tbl.push_back(mkv(0, 3'd4, 3'd2, 64'hBEEF_0000, 64'h0, 5'd5, 1'b1, 64'h0000_BEEF, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd0, 3'd3, 64'h0, 64'hDEAD_BEEF, 5'd6, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd2, 3'd2, 64'h8000_1234, 64'h0, 5'd7, 1'b1, 64'hFFFF_8000, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd5, 3'd0, 64'hCAFE_F00D, 64'h0, 5'd8, 1'b1, 64'hCAFE_F00D, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd5, 3'd2, 64'hCAFE_F00D, 64'h0, 5'd9, 1'b1, 64'h0, 1'b0, 1'b1));
        tbl.push_back(mkv(0, 3'd6, 3'd0, 64'h89AB_CDEF, 64'h0, 5'd10, 1'b1, 64'h89AB_CDEF, 1'b1, 1'b0));
        tbl.push_back(mkv(0, 3'd7, 3'd0, 64'h89AB_CDEF, 64'h0, 5'd11, 1'b1, 64'h0, 1'b0, 1'b0));
        tbl.push_back(mkv(0, 3'd1, 3'd3, 64'h7F00_0000, 64'h0, 5'd12, 1'b0, 64'h0000_007F, 1'b0, 1'b0));
        tbl.push_back(mkv(0, 3'd0, 3'd0, 64'h0, 64'h1111_1111, 5'd0, 1'b1, 64'h1111_1111, 1'b0, 1'b0));
        tbl.push_back(mkv(0, 3'd3, 3'd1, 64'h0000_AB00, 64'h0, 5'd31, 1'b1, 64'h0000_00AB, 1'b1, 1'b0));
        // 64-bit datapath
        tbl.push_back(mkv(1, 3'd5, 3'd4, 64'h8000_0001_0000_0000, 64'h0, 5'd1, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0));
        tbl.push_back(mkv(1, 3'd6, 3'd4, 64'h8000_0001_0000_0000, 64'h0, 5'd2, 1'b1, 64'h0000_0000_8000_0001, 1'b1, 1'b0));
        tbl.push_back(mkv(1, 3'd7, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0));
        tbl.push_back(mkv(1, 3'd7, 3'd4, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd3, 1'b1, 64'h0, 1'b0, 1'b1));
        tbl.push_back(mkv(1, 3'd6, 3'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd5, 1'b1, 64'h0, 1'b0, 1'b1));
        tbl.push_back(mkv(1, 3'd2, 3'd6, 64'hFEDC_0000_0000_0000, 64'h0, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FEDC, 1'b1, 1'b0));
        tbl.push_back(mkv(1, 3'd4, 3'd7, 64'hFEDC_0000_0000_0000, 64'h0, 5'd6, 1'b1, 64'h0, 1'b0, 1'b1));
        tbl.push_back(mkv(1, 3'd1, 3'd7, 64'h8100_0000_0000_0000, 64'h0, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF81, 1'b1, 1'b0));

        #22;
        check_zero();
        rstn = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);
        idle();

        // valid entry held by stall while new work waits, then released
        apply(mkv(0, 3'd0, 3'd0, 64'h0, 64'hA5A5_A5A5, 5'd2, 1'b1, 64'hA5A5_A5A5, 1'b1, 1'b0));
        stall = 1'b1;
        for (int k = 0; k < 3; k++)
            apply(mkv(0, 3'd0, 3'd0, 64'h0, 64'h5A5A_5A5A, 5'd9, 1'b1, 64'h5A5A_5A5A, 1'b1, 1'b0));
        stall = 1'b0;
        apply(mkv(0, 3'd0, 3'd0, 64'h0, 64'h5A5A_5A5A, 5'd9, 1'b1, 64'h5A5A_5A5A, 1'b1, 1'b0));
        idle();

        // stall with an empty stage still accepts
        stall = 1'b1;
        apply(mkv(1, 3'd3, 3'd5, 64'h0000_AA00_0000_0000, 64'h0, 5'd12, 1'b1, 64'h0000_0000_0000_00AA, 1'b1, 1'b0));
        stall = 1'b0;
        idle();

        // flush beats capture; flush beats stall without retiring
        apply(mkv(0, 3'd2, 3'd1, 64'h0, 64'h0, 5'd13, 1'b1, 64'h0, 1'b0, 1'b1));
        flush = 1'b1;
        apply(mkv(0, 3'd0, 3'd0, 64'h0, 64'h7777_7777, 5'd14, 1'b1, 64'h7777_7777, 1'b1, 1'b0));
        flush = 1'b0;
        apply(mkv(1, 3'd0, 3'd0, 64'h0, 64'h1234_5678_9ABC_DEF0, 5'd15, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0));
        flush = 1'b1; stall = 1'b1;
        apply(mkv(1, 3'd0, 3'd0, 64'h0, 64'h1, 5'd16, 1'b1, 64'h1, 1'b1, 1'b0));
        flush = 1'b0; stall = 1'b0;
        idle();

        // back-to-back stream interrupted by reset
        for (int k = 0; k < 5; k++)
            apply(mkv(1, 3'd0, 3'd0, 64'h0, 64'(k + 100), 5'(k + 1), 1'b1, 64'(k + 100), 1'b1, 1'b0));
        rstn = 1'b0;
        #1;
        check_zero();
        m32 = st_zero(); m64 = st_zero(); mc32 = 4'd0; mc64 = 32'd0;
        q32.delete(); q64.delete();
        iv32 = 1'b0; iv64 = 1'b0;
        #2;
        rstn = 1'b1;
        idle();
        apply(mkv(0, 3'd0, 3'd0, 64'h0, 64'h0BAD_F00D, 5'd1, 1'b1, 64'h0BAD_F00D, 1'b1, 1'b0));
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
